// File: rtl/noc_link_rx.sv
`default_nettype none
// ============================================================================
// Module : noc_link_rx
// Brief  : Flit link receive endpoint: FIFO buffering, credit return,
//          valid/ready output stream and per-packet framing monitor.
//          Optional macro NOC_LINK_RX_OVERFLOW_CHECK_EN adds overflow detection.
// Rev    : 1.0 - initial release
// ============================================================================
module noc_link_rx #(
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int PKT_COUNT_WIDTH   = 16
) (
    input  logic                       clk_noc,
    input  logic                       rst_n,
    input  logic [FLIT_WIDTH-1:0]      data_in,
    input  logic [DEST_WIDTH-1:0]      dest_in,
    input  logic                       is_tail_in,
    input  logic                       send_in,
    output logic                       credit_out,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [FLIT_WIDTH-1:0]      m_tdata,
    output logic [DEST_WIDTH-1:0]      m_tdest,
    output logic                       m_tlast,
    output logic [PKT_COUNT_WIDTH-1:0] pkt_count,
    output logic                       dest_err,
    output logic                       overflow
);

    localparam int c_PTR_W = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FLIT_BUFFER_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FLIT_BUFFER_DEPTH);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_IN_PKT = 1'b1;

    logic [FLIT_WIDTH-1:0] r_mem_data [FLIT_BUFFER_DEPTH];
    logic [DEST_WIDTH-1:0] r_mem_dest [FLIT_BUFFER_DEPTH];
    logic                  r_mem_tail [FLIT_BUFFER_DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_credit;

    logic [0:0]                 r_state;
    logic [0:0]                 w_state_nxt;
    logic [DEST_WIDTH-1:0]      r_pkt_dest;
    logic [DEST_WIDTH-1:0]      w_pkt_dest_nxt;
    logic [PKT_COUNT_WIDTH-1:0] r_pkt_count;
    logic [PKT_COUNT_WIDTH-1:0] w_pkt_count_nxt;
    logic                       r_dest_err;
    logic                       w_dest_err_nxt;

    logic w_push;
    logic w_pop;

    assign m_tvalid = (r_count != '0);
    assign w_pop    = m_tvalid & m_tready;
    // A full FIFO still accepts a flit when the head leaves on the same edge.
    assign w_push   = send_in & ((r_count < c_CNT_FULL) | w_pop);

    assign m_tdata  = r_mem_data[r_rd_ptr];
    assign m_tdest  = r_mem_dest[r_rd_ptr];
    assign m_tlast  = r_mem_tail[r_rd_ptr];

    assign credit_out = r_credit;
    assign pkt_count  = r_pkt_count;
    assign dest_err   = r_dest_err;

    // Storage carries no reset; contents are qualified by r_count.
    always_ff @(posedge clk_noc) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= data_in;
            r_mem_dest[r_wr_ptr] <= dest_in;
            r_mem_tail[r_wr_ptr] <= is_tail_in;
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_credit <= 1'b0;
        end else begin
            r_credit <= w_pop;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_pkt_dest  <= '0;
            r_pkt_count <= '0;
            r_dest_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pkt_dest  <= w_pkt_dest_nxt;
            r_pkt_count <= w_pkt_count_nxt;
            r_dest_err  <= w_dest_err_nxt;
        end
    end

    // Framing monitor only moves when a flit leaves the FIFO.
    always_comb begin
        w_state_nxt     = r_state;
        w_pkt_dest_nxt  = r_pkt_dest;
        w_pkt_count_nxt = r_pkt_count;
        w_dest_err_nxt  = r_dest_err;
        if (w_pop) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (m_tlast) begin
                        w_pkt_count_nxt = r_pkt_count + 1'b1;
                    end else begin
                        w_pkt_dest_nxt = m_tdest;
                        w_state_nxt    = c_ST_IN_PKT;
                    end
                end
                c_ST_IN_PKT: begin
                    if (m_tdest != r_pkt_dest) begin
                        w_dest_err_nxt = 1'b1;
                    end
                    if (m_tlast) begin
                        w_pkt_count_nxt = r_pkt_count + 1'b1;
                        w_state_nxt     = c_ST_IDLE;
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

`ifdef NOC_LINK_RX_OVERFLOW_CHECK_EN
    logic r_overflow;

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (send_in && (r_count == c_CNT_FULL) && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_link_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_noc_link_rx
// Brief  : Self-checking bench for noc_link_rx against a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_noc_link_rx;

    localparam int FW    = 64;
    localparam int DW    = 6;
    localparam int DEPTH = 2;
    localparam int PCW   = 16;
`ifdef NOC_LINK_RX_OVERFLOW_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic           clk_noc = 1'b0;
    logic           rst_n   = 1'b0;
    logic [FW-1:0]  data_in = '0;
    logic [DW-1:0]  dest_in = '0;
    logic           is_tail_in = 1'b0;
    logic           send_in = 1'b0;
    logic           m_tready = 1'b0;
    logic           credit_out;
    logic           m_tvalid;
    logic [FW-1:0]  m_tdata;
    logic [DW-1:0]  m_tdest;
    logic           m_tlast;
    logic [PCW-1:0] pkt_count;
    logic           dest_err;
    logic           overflow;

    noc_link_rx #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
        .FLIT_BUFFER_DEPTH(DEPTH), .PKT_COUNT_WIDTH(PCW)
    ) dut (
        .clk_noc(clk_noc), .rst_n(rst_n),
        .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
        .credit_out(credit_out),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tdata(m_tdata), .m_tdest(m_tdest), .m_tlast(m_tlast),
        .pkt_count(pkt_count), .dest_err(dest_err), .overflow(overflow)
    );

    always #5 clk_noc = ~clk_noc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [FW-1:0] d;
        logic [DW-1:0] t;
        logic          l;
    } flit_t;

    // Reference model: buffered flits, packet bookkeeping, sender credits.
    flit_t         q[$];
    bit            m_in_pkt;
    logic [DW-1:0] m_pdest;
    int            m_pkt;
    bit            m_err;
    bit            m_ovf;
    bit            m_credit;
    int            credits;

    task automatic model_reset();
        q.delete();
        m_in_pkt = 0; m_pdest = '0; m_pkt = 0;
        m_err = 0; m_ovf = 0; m_credit = 0;
        credits = DEPTH;
    endtask

    // Applies the current inputs to the model, then advances one clock.
    task automatic step();
        flit_t f;
        bit pop, push;
        pop  = (q.size() != 0) && m_tready;
        push = send_in && ((q.size() < DEPTH) || pop);
        if (send_in && q.size() == DEPTH && !pop) m_ovf = OVF_EN;
        if (pop) begin
            f = q.pop_front();
            if (!m_in_pkt) begin
                if (f.l) m_pkt++;
                else begin m_in_pkt = 1; m_pdest = f.t; end
            end else begin
                if (f.t != m_pdest) m_err = 1;
                if (f.l) begin m_pkt++; m_in_pkt = 0; end
            end
        end
        if (push) begin
            f.d = data_in; f.t = dest_in; f.l = is_tail_in;
            q.push_back(f);
        end
        m_credit = pop;
        credits  = credits + int'(credit_out) - int'(send_in);
        @(posedge clk_noc); #1;
    endtask

    // Credit-honouring sender: a pulse seen this cycle is usable immediately.
    task automatic offer(input bit want, input logic [FW-1:0] d, input logic [DW-1:0] t, input logic l);
        send_in    = want && ((credits + int'(credit_out)) > 0);
        data_in    = d;
        dest_in    = t;
        is_tail_in = l;
    endtask

    task automatic idle(input int n);
        send_in = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_tready = 1'b1; send_in = 1'b1;
        repeat (3) @(posedge clk_noc);
        #1;
        total++; if (m_tvalid !== 1'b0)   begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
        total++; if (credit_out !== 1'b0) begin bad++; $display("FAIL reset_credit got=%b exp=0", credit_out); end
        total++; if (pkt_count !== '0)    begin bad++; $display("FAIL reset_pkt got=%0d exp=0", pkt_count); end
        total++; if (dest_err !== 1'b0)   begin bad++; $display("FAIL reset_dest_err got=%b exp=0", dest_err); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        send_in = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk_noc); #1;
    endtask

    task automatic test_single_flit();
        m_tready = 1'b1;
        offer(1'b1, 64'hA5, 6'h05, 1'b1);
        step();
        send_in = 1'b0;
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL single_tvalid got=%b exp=1", m_tvalid); end
        total++; if (m_tdata !== 64'hA5 || m_tdest !== 6'h05 || m_tlast !== 1'b1)
            begin bad++; $display("FAIL single_head got=%h/%h/%b exp=a5/05/1", m_tdata, m_tdest, m_tlast); end
        total++; if (credit_out !== 1'b0) begin bad++; $display("FAIL single_credit_early got=%b exp=0", credit_out); end
        step();
        total++; if (m_tvalid !== 1'b0)   begin bad++; $display("FAIL single_drained got=%b exp=0", m_tvalid); end
        total++; if (credit_out !== 1'b1) begin bad++; $display("FAIL single_credit got=%b exp=1", credit_out); end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL single_pkt got=%0d exp=1", pkt_count); end
        step();
        total++; if (credit_out !== 1'b0) begin bad++; $display("FAIL single_credit_width got=%b exp=0", credit_out); end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] d [4];
        int sent = 0, rcvd = 0, creds = 0, base = m_pkt;
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        for (int cyc = 0; cyc < 40 && rcvd < 4; cyc++) begin
            m_tready = (cyc >= 5);
            if (credit_out) creds++;
            if (cyc == 5) begin
                total++; if (sent != 2 || m_tvalid !== 1'b1 || m_tdata !== d[0])
                    begin bad++; $display("FAIL bp_fill sent=%0d valid=%b head=%h exp=2/1/%h", sent, m_tvalid, m_tdata, d[0]); end
            end
            if (m_tvalid && m_tready) begin
                total++; if (m_tdata !== d[rcvd] || m_tlast !== (rcvd == 3))
                    begin bad++; $display("FAIL bp_order idx=%0d got=%h/%b exp=%h/%b", rcvd, m_tdata, m_tlast, d[rcvd], rcvd == 3); end
                rcvd++;
            end
            offer(sent < 4, d[(sent < 4) ? sent : 0], 6'h12, sent == 3);
            if (send_in) sent++;
            step();
        end
        send_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (credit_out) creds++;
            step();
        end
        total++; if (rcvd != 4)  begin bad++; $display("FAIL bp_received got=%0d exp=4", rcvd); end
        total++; if (creds != 4) begin bad++; $display("FAIL bp_credits got=%0d exp=4", creds); end
        total++; if (pkt_count !== PCW'(base + 1)) begin bad++; $display("FAIL bp_pkt got=%0d exp=%0d", pkt_count, base + 1); end
        total++; if (dest_err !== 1'b0) begin bad++; $display("FAIL bp_dest_err got=%b exp=0", dest_err); end
    endtask

    task automatic test_dest_err();
        logic [DW-1:0] dst [3];
        int sent = 0, pops = 0, base = m_pkt;
        bit p;
        dst[0] = 6'h12; dst[1] = 6'h13; dst[2] = 6'h12;
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 30 && pops < 3; cyc++) begin
            p = (q.size() != 0);
            offer(sent < 3, {$urandom, $urandom}, dst[(sent < 3) ? sent : 0], sent == 2);
            if (send_in) sent++;
            step();
            if (p) begin
                pops++;
                total++; if (dest_err !== (pops >= 2))
                    begin bad++; $display("FAIL derr_after_pop%0d got=%b exp=%b", pops, dest_err, pops >= 2); end
            end
        end
        idle(3);
        total++; if (pops != 3) begin bad++; $display("FAIL derr_pops got=%0d exp=3", pops); end
        total++; if (dest_err !== 1'b1) begin bad++; $display("FAIL derr_sticky got=%b exp=1", dest_err); end
        total++; if (pkt_count !== PCW'(base + 1)) begin bad++; $display("FAIL derr_pkt got=%0d exp=%0d", pkt_count, base + 1); end
    endtask

    task automatic test_throughput();
        int sent = 0, rcvd = 0, first = -1, last = -1;
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 60 && rcvd < 20; cyc++) begin
            if (m_tvalid) begin
                if (first < 0) first = cyc;
                last = cyc;
                total++; if (q.size() == 0 || m_tdata !== q[0].d)
                    begin bad++; $display("FAIL tput_data cyc=%0d got=%h", cyc, m_tdata); end
                rcvd++;
            end
            offer(sent < 20, {$urandom, $urandom}, 6'h2A, (sent % 4) == 3);
            if (send_in) sent++;
            step();
        end
        idle(3);
        total++; if (rcvd != 20) begin bad++; $display("FAIL tput_count got=%0d exp=20", rcvd); end
        total++; if (last - first + 1 != 20)
            begin bad++; $display("FAIL tput_bubbles span=%0d exp=20", last - first + 1); end
    endtask

    task automatic test_random();
        logic [DW-1:0] pd = DW'($urandom);
        logic [DW-1:0] fd;
        logic          tl;
        for (int cyc = 0; cyc < 400; cyc++) begin
            m_tready = ($urandom_range(0, 9) < 7);
            fd = ($urandom_range(0, 15) == 0) ? (pd ^ 6'h01) : pd;
            tl = ($urandom_range(0, 3) == 0);
            offer($urandom_range(0, 9) < 8, {$urandom, $urandom}, fd, tl);
            if (send_in && tl) pd = DW'($urandom);
            total++; if (m_tvalid !== (q.size() != 0))
                begin bad++; $display("FAIL rnd_tvalid cyc=%0d got=%b exp=%b", cyc, m_tvalid, q.size() != 0); end
            if (q.size() != 0) begin
                total++; if (m_tdata !== q[0].d || m_tdest !== q[0].t || m_tlast !== q[0].l)
                    begin bad++; $display("FAIL rnd_head cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, m_tdata, m_tdest, m_tlast, q[0].d, q[0].t, q[0].l); end
            end
            total++; if (credit_out !== m_credit)
                begin bad++; $display("FAIL rnd_credit cyc=%0d got=%b exp=%b", cyc, credit_out, m_credit); end
            total++; if (pkt_count !== PCW'(m_pkt) || dest_err !== m_err || overflow !== m_ovf)
                begin bad++; $display("FAIL rnd_status cyc=%0d got=%0d/%b/%b exp=%0d/%b/%b", cyc, pkt_count, dest_err, overflow, m_pkt, m_err, m_ovf); end
            step();
        end
        m_tready = 1'b1;
        idle(6);
        total++; if (credits != DEPTH) begin bad++; $display("FAIL rnd_credit_balance got=%0d exp=%0d", credits, DEPTH); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rnd_drained got=%b exp=0", m_tvalid); end
    endtask

`ifdef NOC_LINK_RX_OVERFLOW_CHECK_EN
    task automatic test_overflow();
        logic [FW-1:0] extra = 64'hDEAD_BEEF_0BAD_F00D;
        int rcvd = 0;
        m_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send_in = 1'b1; data_in = 64'(i + 1); dest_in = 6'h09; is_tail_in = (i == 1);
            step();
        end
        send_in = 1'b1; data_in = extra; dest_in = 6'h09; is_tail_in = 1'b1;
        step();
        send_in = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (m_tdata !== 64'd1) begin bad++; $display("FAIL ovf_head got=%h exp=1", m_tdata); end
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (m_tvalid) begin
                rcvd++;
                total++; if (m_tdata === extra) begin bad++; $display("FAIL ovf_leak got=%h", m_tdata); end
            end
            step();
        end
        total++; if (rcvd != 2) begin bad++; $display("FAIL ovf_count got=%0d exp=2", rcvd); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        credits = DEPTH;
    endtask
`endif

    task automatic test_reset_mid();
        m_tready = 1'b0;
        send_in = 1'b1; data_in = 64'h11; dest_in = 6'h21; is_tail_in = 1'b0; step();
        send_in = 1'b1; data_in = 64'h22; step();
        // Pop and refill on the same edge: two flits buffered, credit pulse pending.
        m_tready = 1'b1; send_in = 1'b1; data_in = 64'h33; step();
        send_in = 1'b0; m_tready = 1'b0;
        total++; if (m_tvalid !== 1'b1 || credit_out !== 1'b1)
            begin bad++; $display("FAIL rmid_setup got=%b/%b exp=1/1", m_tvalid, credit_out); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (m_tvalid !== 1'b0)   begin bad++; $display("FAIL rmid_tvalid got=%b exp=0", m_tvalid); end
        total++; if (credit_out !== 1'b0) begin bad++; $display("FAIL rmid_credit got=%b exp=0", credit_out); end
        repeat (2) @(posedge clk_noc);
        #1 rst_n = 1'b1;
        model_reset();
        total++; if (pkt_count !== '0 || m_tvalid !== 1'b0)
            begin bad++; $display("FAIL rmid_release got=%0d/%b exp=0/0", pkt_count, m_tvalid); end
        m_tready = 1'b1;
        offer(1'b1, 64'h44, 6'h07, 1'b1);
        step();
        idle(2);
        total++; if (dest_err !== 1'b0)   begin bad++; $display("FAIL rmid_fsm_idle got=%b exp=0", dest_err); end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL rmid_pkt got=%0d exp=1", pkt_count); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_flit();
        test_backpressure();
        test_dest_err();
        test_throughput();
        test_random();
`ifdef NOC_LINK_RX_OVERFLOW_CHECK_EN
        test_overflow();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
